// File: rtl/bp_stream_mmio_bridge.sv
// MMIO command/response to narrow word-stream bridge: commands are serialised as
// header/address/data words, read responses are reassembled from the inbound stream.
module bp_stream_mmio_bridge #(
    parameter int addr_width_p        = 40,
    parameter int data_width_p        = 64,
    parameter int stream_data_width_p = 32,
    parameter int tag_width_p         = 8,
    parameter int queue_els_p         = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic                           mmio_cmd_v_i,
    input  logic                           mmio_cmd_w_i,
    input  logic [addr_width_p-1:0]        mmio_cmd_addr_i,
    input  logic [data_width_p-1:0]        mmio_cmd_data_i,
    input  logic [tag_width_p-1:0]         mmio_cmd_tag_i,
    output logic                           mmio_cmd_yumi_o,

    output logic                           mmio_resp_v_o,
    output logic                           mmio_resp_w_o,
    output logic [addr_width_p-1:0]        mmio_resp_addr_o,
    output logic [data_width_p-1:0]        mmio_resp_data_o,
    output logic [tag_width_p-1:0]         mmio_resp_tag_o,
    input  logic                           mmio_resp_ready_i,

    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_yumi_i,

    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_ready_o
);

    localparam int sw_lp      = stream_data_width_p;
    localparam int na_lp      = (addr_width_p + sw_lp - 1) / sw_lp;
    localparam int nd_lp      = (data_width_p + sw_lp - 1) / sw_lp;
    localparam int pkt_max_lp = 1 + na_lp + nd_lp;
    localparam int cnt_w_lp   = $clog2(pkt_max_lp);
    localparam int rx_w_lp    = $clog2(nd_lp + 1);
    localparam int qptr_w_lp  = $clog2(queue_els_p);
    localparam int qent_w_lp  = 1 + addr_width_p + tag_width_p;

    // ---------------- outbound serialiser ----------------
    logic [cnt_w_lp-1:0]         cnt_r;
    logic [cnt_w_lp-1:0]         last_idx_s;
    logic [pkt_max_lp*sw_lp-1:0] pkt_s;
    logic [sw_lp-1:0]            word_s;
    logic                        push_s;
    logic                        last_s;
    logic                        queue_ready_s;
    logic                        ofifo_ready_s;

    logic [sw_lp-1:0]            ofifo_mem_r [2];
    logic                        ofifo_wr_r;
    logic                        ofifo_rd_r;
    logic [1:0]                  ofifo_cnt_r;
    logic                        pop_s;

    // Flatten the command into packet words and pick the one at cnt_r
    always_comb begin
        pkt_s                                     = '0;
        pkt_s[sw_lp-1]                            = mmio_cmd_w_i;
        pkt_s[sw_lp +: addr_width_p]              = mmio_cmd_addr_i;
        pkt_s[(1+na_lp)*sw_lp +: data_width_p]    = mmio_cmd_data_i;
        word_s                                    = '0;
        for (int i = 0; i < pkt_max_lp; i++) begin
            word_s = (cnt_r == cnt_w_lp'(i)) ? pkt_s[i*sw_lp +: sw_lp] : word_s;
        end
    end

    assign last_idx_s     = mmio_cmd_w_i ? cnt_w_lp'(pkt_max_lp - 1) : cnt_w_lp'(na_lp);
    assign ofifo_ready_s  = (ofifo_cnt_r != 2'd2);
    // Only a fresh packet needs a guaranteed queue slot; one in progress already owns it
    assign push_s         = mmio_cmd_v_i & ofifo_ready_s & ((cnt_r != '0) | queue_ready_s);
    assign last_s         = push_s & (cnt_r == last_idx_s);
    assign mmio_cmd_yumi_o = last_s;

    assign pop_s          = stream_yumi_i & (ofifo_cnt_r != 2'd0);
    assign stream_v_o     = (ofifo_cnt_r != 2'd0);
    assign stream_data_o  = ofifo_mem_r[ofifo_rd_r];

    // Packet word counter
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r <= '0;
        end else if (last_s) begin
            cnt_r <= '0;
        end else if (push_s) begin
            cnt_r <= cnt_r + cnt_w_lp'(1);
        end
    end

    // Two-entry outbound word FIFO
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ofifo_mem_r[0] <= '0;
            ofifo_mem_r[1] <= '0;
            ofifo_wr_r     <= 1'b0;
            ofifo_rd_r     <= 1'b0;
            ofifo_cnt_r    <= 2'd0;
        end else begin
            if (push_s) begin
                ofifo_mem_r[ofifo_wr_r] <= word_s;
                ofifo_wr_r              <= ~ofifo_wr_r;
            end
            if (pop_s) begin
                ofifo_rd_r <= ~ofifo_rd_r;
            end
            case ({push_s, pop_s})
                2'b10:   ofifo_cnt_r <= ofifo_cnt_r + 2'd1;
                2'b01:   ofifo_cnt_r <= ofifo_cnt_r - 2'd1;
                default: ofifo_cnt_r <= ofifo_cnt_r;
            endcase
        end
    end

    // ---------------- pending command queue ----------------
    logic [qent_w_lp-1:0]  q_mem_r [queue_els_p];
    logic [qptr_w_lp-1:0]  q_wr_r;
    logic [qptr_w_lp-1:0]  q_rd_r;
    logic [qptr_w_lp:0]    q_cnt_r;
    logic [qent_w_lp-1:0]  head_s;
    logic                  q_nonempty_s;
    logic                  deq_s;

    assign queue_ready_s = (q_cnt_r != (qptr_w_lp+1)'(queue_els_p));
    assign q_nonempty_s  = (q_cnt_r != '0);
    assign head_s        = q_mem_r[q_rd_r];

    // Queue storage; contents are only meaningful under q_cnt_r, so no reset needed
    always_ff @(posedge clk_i) begin
        if (last_s) begin
            q_mem_r[q_wr_r] <= {mmio_cmd_w_i, mmio_cmd_addr_i, mmio_cmd_tag_i};
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            q_wr_r  <= '0;
            q_rd_r  <= '0;
            q_cnt_r <= '0;
        end else begin
            if (last_s) begin
                q_wr_r <= q_wr_r + qptr_w_lp'(1);
            end
            if (deq_s) begin
                q_rd_r <= q_rd_r + qptr_w_lp'(1);
            end
            case ({last_s, deq_s})
                2'b10:   q_cnt_r <= q_cnt_r + (qptr_w_lp+1)'(1);
                2'b01:   q_cnt_r <= q_cnt_r - (qptr_w_lp+1)'(1);
                default: q_cnt_r <= q_cnt_r;
            endcase
        end
    end

    // ---------------- response side ----------------
    logic [nd_lp*sw_lp-1:0] data_r;
    logic [rx_w_lp-1:0]     rx_cnt_r;
    logic                   head_w_s;
    logic                   rx_acc_s;

    assign head_w_s         = head_s[qent_w_lp-1];
    assign stream_ready_o   = q_nonempty_s & ~head_w_s & (rx_cnt_r < rx_w_lp'(nd_lp));
    assign rx_acc_s         = stream_ready_o & stream_v_i;
    assign mmio_resp_v_o    = q_nonempty_s & (head_w_s | (rx_cnt_r == rx_w_lp'(nd_lp)));
    assign deq_s            = mmio_resp_v_o & mmio_resp_ready_i;
    assign mmio_resp_w_o    = head_w_s;
    assign mmio_resp_addr_o = head_s[tag_width_p +: addr_width_p];
    assign mmio_resp_tag_o  = head_s[tag_width_p-1:0];
    // data_r stays zero while a write is at the head, so writes report 0
    assign mmio_resp_data_o = data_r[data_width_p-1:0];

    // Read data assembly, least-significant word first
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_r   <= '0;
            rx_cnt_r <= '0;
        end else if (deq_s) begin
            data_r   <= '0;
            rx_cnt_r <= '0;
        end else if (rx_acc_s) begin
            for (int i = 0; i < nd_lp; i++) begin
                if (rx_cnt_r == rx_w_lp'(i)) begin
                    data_r[i*sw_lp +: sw_lp] <= stream_data_i;
                end
            end
            rx_cnt_r <= rx_cnt_r + rx_w_lp'(1);
        end
    end

endmodule

// File: tb/tb_bp_stream_mmio_bridge.sv
// Directed self-checking bench for bp_stream_mmio_bridge at default widths.
module tb_bp_stream_mmio_bridge;

    localparam int AW = 40;
    localparam int DW = 64;
    localparam int SW = 32;
    localparam int TW = 8;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          mmio_cmd_v_i, mmio_cmd_w_i;
    logic [AW-1:0] mmio_cmd_addr_i;
    logic [DW-1:0] mmio_cmd_data_i;
    logic [TW-1:0] mmio_cmd_tag_i;
    logic          mmio_cmd_yumi_o;
    logic          mmio_resp_v_o, mmio_resp_w_o;
    logic [AW-1:0] mmio_resp_addr_o;
    logic [DW-1:0] mmio_resp_data_o;
    logic [TW-1:0] mmio_resp_tag_o;
    logic          mmio_resp_ready_i;
    logic          stream_v_o;
    logic [SW-1:0] stream_data_o;
    logic          stream_yumi_i;
    logic          stream_v_i;
    logic [SW-1:0] stream_data_i;
    logic          stream_ready_o;

    always #5 clk_i = ~clk_i;

    bp_stream_mmio_bridge dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .mmio_cmd_v_i(mmio_cmd_v_i), .mmio_cmd_w_i(mmio_cmd_w_i),
        .mmio_cmd_addr_i(mmio_cmd_addr_i), .mmio_cmd_data_i(mmio_cmd_data_i),
        .mmio_cmd_tag_i(mmio_cmd_tag_i), .mmio_cmd_yumi_o(mmio_cmd_yumi_o),
        .mmio_resp_v_o(mmio_resp_v_o), .mmio_resp_w_o(mmio_resp_w_o),
        .mmio_resp_addr_o(mmio_resp_addr_o), .mmio_resp_data_o(mmio_resp_data_o),
        .mmio_resp_tag_o(mmio_resp_tag_o), .mmio_resp_ready_i(mmio_resp_ready_i),
        .stream_v_o(stream_v_o), .stream_data_o(stream_data_o), .stream_yumi_i(stream_yumi_i),
        .stream_v_i(stream_v_i), .stream_data_i(stream_data_i), .stream_ready_o(stream_ready_o)
    );

    typedef struct packed {
        logic          w;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
    } resp_t;

    logic [SW-1:0] sent_q [$];
    resp_t         resp_q [$];
    int            yumi_cnt = 0;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record completed handshakes away from the active edge
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (stream_v_o && stream_yumi_i) sent_q.push_back(stream_data_o);
            if (mmio_resp_v_o && mmio_resp_ready_i)
                resp_q.push_back({mmio_resp_w_o, mmio_resp_addr_o, mmio_resp_data_o, mmio_resp_tag_o});
            if (mmio_cmd_yumi_o) yumi_cnt++;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [TW-1:0] t);
        bit done = 1'b0;
        mmio_cmd_v_i = 1'b1; mmio_cmd_w_i = w; mmio_cmd_addr_i = a;
        mmio_cmd_data_i = d; mmio_cmd_tag_i = t;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            if (mmio_cmd_yumi_o) done = 1'b1;
            else step();
        end
        if (!done) check_val("issue_timeout", 64'd0, 64'd1);
        step();
        mmio_cmd_v_i = 1'b0;
    endtask

    task automatic feed(input logic [SW-1:0] wd);
        bit done = 1'b0;
        stream_v_i = 1'b1; stream_data_i = wd;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            if (stream_ready_o) done = 1'b1;
            else step();
        end
        if (!done) check_val("feed_timeout", 64'd0, 64'd1);
        step();
        stream_v_i = 1'b0;
    endtask

    logic [SW-1:0] wr_words [5];
    logic [SW-1:0] rd_words [3];
    int            yumi_base;

    initial begin
        wr_words[0] = 32'h8000_0000; wr_words[1] = 32'h3456_789A; wr_words[2] = 32'h0000_0012;
        wr_words[3] = 32'h5566_7788; wr_words[4] = 32'h1122_3344;
        rd_words[0] = 32'h0000_0000; rd_words[1] = 32'h0000_0040; rd_words[2] = 32'h0000_0000;

        reset_i = 1'b1; mmio_cmd_v_i = 1'b0; mmio_cmd_w_i = 1'b0; mmio_cmd_addr_i = '0;
        mmio_cmd_data_i = '0; mmio_cmd_tag_i = '0; mmio_resp_ready_i = 1'b1;
        stream_yumi_i = 1'b1; stream_v_i = 1'b0; stream_data_i = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_val("rst_yumi", 64'(mmio_cmd_yumi_o), 64'd0);
        check_val("rst_resp_v", 64'(mmio_resp_v_o), 64'd0);
        check_val("rst_stream_v", 64'(stream_v_o), 64'd0);
        check_val("rst_stream_ready", 64'(stream_ready_o), 64'd0);
        step();
        reset_i = 1'b0;

        // Write: cycle-exact word order, yumi in cycle 5, response the next cycle
        mmio_cmd_v_i = 1'b1; mmio_cmd_w_i = 1'b1; mmio_cmd_addr_i = 40'h12_3456_789A;
        mmio_cmd_data_i = 64'h1122_3344_5566_7788; mmio_cmd_tag_i = 8'd5;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_i);
            if (k <= 5) check_val($sformatf("wr_yumi_c%0d", k), 64'(mmio_cmd_yumi_o), 64'(k == 5));
            if (k >= 2) check_val($sformatf("wr_word%0d", k - 2), 64'(stream_data_o), 64'(wr_words[k-2]));
            if (k == 6) begin
                check_val("wr_resp_v", 64'(mmio_resp_v_o), 64'd1);
                check_val("wr_resp_w", 64'(mmio_resp_w_o), 64'd1);
                check_val("wr_resp_addr", 64'(mmio_resp_addr_o), 64'h12_3456_789A);
                check_val("wr_resp_data", mmio_resp_data_o, 64'd0);
                check_val("wr_resp_tag", 64'(mmio_resp_tag_o), 64'd5);
            end
            step();
            if (k == 5) mmio_cmd_v_i = 1'b0;
        end
        @(negedge clk_i);
        check_val("wr_drained", 64'(stream_v_o), 64'd0);
        step();

        // Read with two inbound words
        sent_q.delete(); resp_q.delete();
        fork
            issue(1'b0, 40'h40, 64'd0, 8'd9);
            begin feed(32'hDEAD_BEEF); feed(32'h0BAD_F00D); end
        join
        repeat (3) step();
        check_val("rd_words_n", 64'(sent_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < sent_q.size(); i++)
            check_val($sformatf("rd_word%0d", i), 64'(sent_q[i]), 64'(rd_words[i]));
        check_val("rd_resp_n", 64'(resp_q.size()), 64'd1);
        if (resp_q.size() > 0) begin
            check_val("rd_resp_data", resp_q[0].data, 64'h0BAD_F00D_DEAD_BEEF);
            check_val("rd_resp_tag", 64'(resp_q[0].tag), 64'd9);
            check_val("rd_resp_w", 64'(resp_q[0].w), 64'd0);
        end

        // Read/write/read ordering; write held behind first read
        resp_q.delete();
        mmio_resp_ready_i = 1'b0;
        issue(1'b0, 40'h100, 64'd0, 8'd1);
        issue(1'b1, 40'h200, 64'hAB, 8'd2);
        issue(1'b0, 40'h300, 64'd0, 8'd3);
        repeat (4) step();
        @(negedge clk_i);
        check_val("ord_withheld", 64'(mmio_resp_v_o), 64'd0);
        check_val("ord_ready_head_rd", 64'(stream_ready_o), 64'd1);
        step();
        feed(32'h0000_0A01); feed(32'h0000_0A02);
        @(negedge clk_i);
        check_val("ord_r1_v", 64'(mmio_resp_v_o), 64'd1);
        check_val("ord_r1_tag", 64'(mmio_resp_tag_o), 64'd1);
        check_val("ord_rx_full_ready", 64'(stream_ready_o), 64'd0);
        step();
        mmio_resp_ready_i = 1'b1;
        step();
        mmio_resp_ready_i = 1'b0;
        @(negedge clk_i);
        check_val("ord_wr_head_w", 64'(mmio_resp_w_o), 64'd1);
        check_val("ord_wr_head_ready", 64'(stream_ready_o), 64'd0);
        step();
        mmio_resp_ready_i = 1'b1;
        feed(32'h0000_0B01); feed(32'h0000_0B02);
        repeat (2) step();
        check_val("ord_n", 64'(resp_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < resp_q.size(); i++)
            check_val($sformatf("ord_tag%0d", i), 64'(resp_q[i].tag), 64'(i + 1));
        if (resp_q.size() == 3) begin
            check_val("ord_r1_data", resp_q[0].data, 64'h0000_0A02_0000_0A01);
            check_val("ord_w_data", resp_q[1].data, 64'd0);
            check_val("ord_r3_data", resp_q[2].data, 64'h0000_0B02_0000_0B01);
        end

        // Queue full: 16 reads accepted, the 17th holds until a slot frees
        sent_q.delete(); resp_q.delete();
        yumi_base = yumi_cnt;
        for (int i = 0; i < 16; i++) issue(1'b0, 40'(i * 8), 64'd0, 8'(16 + i));
        fork
            issue(1'b0, 40'h999, 64'd0, 8'd99);
            begin
                repeat (10) step();
                @(negedge clk_i);
                check_val("full_yumis", 64'(yumi_cnt - yumi_base), 64'd16);
                check_val("full_stream_v", 64'(stream_v_o), 64'd0);
                check_val("full_words", 64'(sent_q.size()), 64'd48);
                check_val("full_head_ready", 64'(stream_ready_o), 64'd1);
                step();
                for (int i = 0; i < 34; i++) feed(32'(32'h1000 + i));
            end
        join
        repeat (4) step();
        check_val("full_resp_n", 64'(resp_q.size()), 64'd17);
        if (resp_q.size() == 17) begin
            check_val("full_first_data", resp_q[0].data, 64'h0000_1001_0000_1000);
            check_val("full_first_tag", 64'(resp_q[0].tag), 64'd16);
            check_val("full_last_tag", 64'(resp_q[16].tag), 64'd99);
            check_val("full_last_data", resp_q[16].data, 64'h0000_1021_0000_1020);
        end

        // Outbound stall mid-packet
        sent_q.delete(); resp_q.delete();
        fork
            issue(1'b1, 40'h12_3456_789A, 64'h1122_3344_5566_7788, 8'd3);
            begin
                repeat (2) step();
                stream_yumi_i = 1'b0;
                repeat (10) step();
                stream_yumi_i = 1'b1;
            end
        join
        repeat (6) step();
        check_val("stall_n", 64'(sent_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < sent_q.size(); i++)
            check_val($sformatf("stall_word%0d", i), 64'(sent_q[i]), 64'(wr_words[i]));
        check_val("stall_resp_n", 64'(resp_q.size()), 64'd1);

        // Asynchronous reset after the second outbound word
        sent_q.delete(); resp_q.delete();
        mmio_cmd_v_i = 1'b1; mmio_cmd_w_i = 1'b1; mmio_cmd_addr_i = 40'h12_3456_789A;
        mmio_cmd_data_i = 64'h1122_3344_5566_7788; mmio_cmd_tag_i = 8'd4;
        repeat (3) @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        check_val("arst_yumi", 64'(mmio_cmd_yumi_o), 64'd0);
        check_val("arst_resp_v", 64'(mmio_resp_v_o), 64'd0);
        check_val("arst_stream_v", 64'(stream_v_o), 64'd0);
        check_val("arst_stream_ready", 64'(stream_ready_o), 64'd0);
        step();
        mmio_cmd_v_i = 1'b0;
        step();
        reset_i = 1'b0;
        sent_q.delete(); resp_q.delete();
        issue(1'b1, 40'h12_3456_789A, 64'h1122_3344_5566_7788, 8'd6);
        repeat (6) step();
        check_val("arst_restart_n", 64'(sent_q.size()), 64'd5);
        if (sent_q.size() > 0) check_val("arst_restart_hdr", 64'(sent_q[0]), 64'h8000_0000);
        check_val("arst_resp_n", 64'(resp_q.size()), 64'd1);
        if (resp_q.size() > 0) check_val("arst_resp_tag", 64'(resp_q[0].tag), 64'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bp_stream_mmio_bridge.md
Name: bp_stream_mmio_bridge

Overview:
Bidirectional MMIO-to-stream bridge that connects a flat MMIO command/response interface to a narrow word stream.
- Each command is serialised onto stream-out as a header word, address words and, for writes, data words.
- Write responses are generated locally.
- Read responses are assembled from words arriving on stream-in, in command order.
- Sits between the I/O side of the memory-end network and the off-chip/host stream link, with configurable widths and outstanding-command depth.

Parameters:
addr_width_p, 40, MMIO address width
data_width_p, 64, MMIO data width
stream_data_width_p, 32, stream word width (sw)
tag_width_p, 8, opaque command tag returned with the response
queue_els_p, 16, maximum outstanding commands (power of 2, >=2)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset; asynchronous, active-high
mmio_cmd_v_i  in  1  command valid
mmio_cmd_w_i  in  1  1=write, 0=read
mmio_cmd_addr_i  in  addr_width_p  address
mmio_cmd_data_i  in  data_width_p  write data
mmio_cmd_tag_i  in  tag_width_p  tag
mmio_cmd_yumi_o  out  1  command consumed
mmio_resp_v_o  out  1  response valid
mmio_resp_w_o  out  1  echoed write bit
mmio_resp_addr_o  out  addr_width_p  echoed address
mmio_resp_data_o  out  data_width_p  read data (0 for writes)
mmio_resp_tag_o  out  tag_width_p  echoed tag
mmio_resp_ready_i  in  1  response sink ready
stream_v_o  out  1  outbound word valid
stream_data_o  out  sw  outbound word
stream_yumi_i  in  1  outbound word taken
stream_v_i  in  1  inbound word valid
stream_data_i  in  sw  inbound word
stream_ready_o  out  1  inbound word accepted when high with stream_v_i

Behaviour:
Word counts and packing:
- Na = ceil(addr_width_p/sw); Nd = ceil(data_width_p/sw).
- Packet length L = 1+Na for a read, 1+Na+Nd for a write.
- Header word: bit[sw-1] = w; all other bits 0.
- Address words follow, then data words, each least-significant word first. The top word is zero-extended.

Outbound serialiser:
- Word counter cnt_r is in 0..L-1 and resets to 0.
- The word at index cnt_r is pushed into an internal 2-entry out FIFO when mmio_cmd_v_i & out_fifo_ready & (cnt_r!=0 | queue_ready). The queue_ready check applies only at word 0.
- cnt_r increments on each push.
- On the push of word L-1: mmio_cmd_yumi_o=1 for one cycle, {w,addr,tag} is enqueued in the pending queue (queue_els_p deep), and cnt_r returns to 0.
- Command inputs must be held stable while mmio_cmd_v_i=1 and before yumi. Yumi is never asserted before the last word is pushed.
- stream_v_o/stream_data_o come from the out FIFO head; an entry pops on stream_yumi_i.
- Throughput: 1 word/cycle with continuous yumi. A 40-bit-address write at sw=32 takes 5 cycles, and yumi is asserted in the 5th cycle.

Response side:
- Head of the pending queue is a write: mmio_resp_v_o=1, data=0, with no stream-in involvement.
- Head is a read:
  - stream_ready_o = queue non-empty & head.w==0 & rx_cnt_r<Nd.
  - Each accepted word is written into slice rx_cnt_r of data_r, and rx_cnt_r increments.
  - Upper bits beyond data_width_p are discarded.
  - mmio_resp_v_o=1 when rx_cnt_r==Nd.
- On mmio_resp_v_o & mmio_resp_ready_i: the queue head is dequeued, and rx_cnt_r and data_r are cleared.
- Responses are strictly in command order, and every field is echoed from the queue.
- stream_ready_o=0 when the queue is empty or the head is a write. Unsolicited inbound words are back-pressured, never dropped.

Boundaries:
- Queue full: no new packet starts (cnt_r stays 0). A packet already in progress completes.
- Enqueue and dequeue in the same cycle are both honoured.
- Stream-out stall (no yumi) stalls the serialiser with no loss.
- Response stall holds rx data.
- The earliest response is the cycle after enqueue.

Reset (async, any time):
- cnt_r, rx_cnt_r, data_r and both FIFOs are cleared.
- Partially sent packets are abandoned.
- All outputs are 0: yumi, resp_v, stream_v, stream_ready.

Test Plan:
- Write addr=0x12_3456_789A, data=0x1122334455667788, tag=5, yumi always 1 -> stream words 0x80000000, 0x3456789A, 0x00000012, 0x55667788, 0x11223344. mmio_cmd_yumi_o in cycle 5. Response w=1, data=0, tag=5, valid the next cycle.
- Read addr=0x40, tag=9; stream-in 0xDEADBEEF then 0x0BADF00D -> stream-out 0x00000000, 0x00000040, 0x00000000. resp data=0x0BADF00DDEADBEEF, tag=9.
- Read, write, read issued back-to-back; write resp withheld until first read's 2 words arrive -> responses in tags order 1, 2, 3.
- 16 reads with no stream-in -> 16 yumis; the 17th command sends no word (stream_v_o stays 0 after drain). stream_ready_o=1 only for the head read.
- stream_yumi_i held 0 for 10 cycles mid-packet, then 1 -> identical word sequence, no duplicates or drops.
- Assert reset_i asynchronously after word 2 of a write -> all outputs 0 immediately. The next command restarts with a header word.
